multicycle_sequencer: RTL and testbench

- Control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared datapath: instruction decoder, ALU, branch comparator, register file and a single memory port.
- It issues memory handshakes, generates the register-file, PC and IR write enables, and counts retired instructions.
- It traps on illegal opcodes and on memory timeouts.

---
 rtl/multicycle_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Control FSM for a multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb,
// drives memory handshakes and datapath write enables, counts retirements, traps.
//
//   state  | meaning
//   FETCH  | request instruction at PC, latch IR on handshake
//   DECODE | classify opcode, trap on illegal
//   EXEC   | ALU/branch compare, latch branch decision
//   MEM    | load/store data access at ALU address
//   WB     | register/PC update, retire
//   TRAP   | absorbing fault state until reset
module multicycle_sequencer #(
  parameter int COUNT_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic               funct3_store,
  input  logic               bra_taken,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               ir_we,
  output logic               pc_we,
  output logic               pc_sel,
  output logic               rf_we,
  output logic [1:0]         rf_src,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               br_lat_q, br_lat_d;
  logic               trap_q, trap_d;
  logic [1:0]         trap_cause_q, trap_cause_d;
  logic [COUNT_W-1:0] retired_q, retired_d;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  logic is_legal, is_jump, timeout_hit, fetch_req;

  // Store classification comes from the opcode; the decoder hint is not needed.
  logic unused_funct3_store;
  assign unused_funct3_store = funct3_store;

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_jump   = is_jal | is_jalr;
  assign is_legal  = is_lui | is_auipc | is_jump | is_branch | is_load |
                     is_store | is_opimm | is_op;

  // Evaluated only on stall cycles; a same-cycle mem_ready takes priority.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pending_q    <= 1'b0;
      wait_cnt_q   <= '0;
      br_lat_q     <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= 2'b00;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      wait_cnt_q   <= wait_cnt_d;
      br_lat_q     <= br_lat_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
      retired_q    <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = 1'b0;
    wait_cnt_d   = '0;
    br_lat_d     = br_lat_q;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    retired_d    = retired_q;
    fetch_req    = 1'b0;

    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    rf_we        = 1'b0;
    rf_src       = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        fetch_req = run | pending_q;
        mem_req   = fetch_req;
        if (fetch_req) begin
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (timeout_hit) begin
            state_d      = S_TRAP;
            trap_d       = 1'b1;
            trap_cause_d = 2'b10;
          end else begin
            pending_d  = 1'b1;
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d      = S_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        br_lat_d = is_branch & bra_taken;
        state_d  = (is_load | is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ready) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d      = S_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = 2'b10;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        pc_we  = 1'b1;
        pc_sel = is_jump | (is_branch & br_lat_q);
        rf_we  = ~(is_branch | is_store);
        if (rf_we) begin
          if (is_load)      rf_src = 2'b10;
          else if (is_jump) rf_src = 2'b11;
          else              rf_src = 2'b01;
        end
        retired_d = retired_q + COUNT_W'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset forces the datapath quiet immediately, even mid-handshake.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      rf_we        = 1'b0;
      rf_src       = 2'b00;
    end
  end

  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (COUNT_W=4, TIMEOUT=4): instruction
// flows, memory stalls, branch/jump selection, illegal/timeout traps, reset, wrap.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [6:0] opcode;
  logic       funct3_store;
  logic       bra_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we;
  logic [1:0] rf_src;
  logic       trap;
  logic [1:0] trap_cause;
  logic [2:0] state;
  logic [3:0] retired;
  logic [8:0] ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, rf_src[1:0]}
  localparam logic [8:0] C_NONE   = 9'b0_0_0_0_0_0_0_00;
  localparam logic [8:0] C_IFETCH = 9'b1_0_0_1_0_0_0_00;
  localparam logic [8:0] C_FREQ   = 9'b1_0_0_0_0_0_0_00;
  localparam logic [8:0] C_LD     = 9'b1_0_1_0_0_0_0_00;
  localparam logic [8:0] C_ST     = 9'b1_1_1_0_0_0_0_00;
  localparam logic [8:0] WB_ALU   = 9'b0_0_0_0_1_0_1_01;
  localparam logic [8:0] WB_LD    = 9'b0_0_0_0_1_0_1_10;
  localparam logic [8:0] WB_NORF  = 9'b0_0_0_0_1_0_0_00;
  localparam logic [8:0] WB_TAKEN = 9'b0_0_0_0_1_1_0_00;
  localparam logic [8:0] WB_JMP   = 9'b0_0_0_0_1_1_1_11;

  multicycle_sequencer #(.COUNT_W(4), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .opcode       (opcode),
    .funct3_store (funct3_store),
    .bra_taken    (bra_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .rf_src       (rf_src),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .state        (state),
    .retired      (retired)
  );

  assign ctl = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, rf_src};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs are already set; check this cycle's state and controls, then advance.
  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [8:0] c);
    #1;
    check({tag, "/state"}, 32'(state), 32'(st));
    check({tag, "/ctl"}, 32'(c), 32'(ctl));
    cyc();
  endtask

  task automatic do_instr(input string tag, input logic [6:0] op, input logic bra,
                          input int waits, input logic [8:0] wb_ctl);
    logic [8:0] mc;
    mc = (op == OP_STORE) ? C_ST : C_LD;
    opcode    = op;
    run       = 1'b1;
    mem_ready = 1'b1;
    expect_cyc({tag, "/F"}, 3'd0, C_IFETCH);
    run = 1'b0;
    expect_cyc({tag, "/D"}, 3'd1, C_NONE);
    bra_taken = bra;
    expect_cyc({tag, "/E"}, 3'd2, C_NONE);
    bra_taken = 1'b0;
    if (op == OP_LOAD || op == OP_STORE) begin
      mem_ready = 1'b0;
      for (int i = 0; i < waits; i++) expect_cyc({tag, "/Mw"}, 3'd3, mc);
      mem_ready = 1'b1;
      expect_cyc({tag, "/Mr"}, 3'd3, mc);
    end
    expect_cyc({tag, "/W"}, 3'd4, wb_ctl);
  endtask

  initial begin
    rst          = 1'b1;
    run          = 1'b1;
    opcode       = OP_OP;
    funct3_store = 1'b0;
    bra_taken    = 1'b0;
    mem_ready    = 1'b1;
    #2;
    check("rst/ctl", 32'(ctl), 32'(C_NONE));
    check("rst/state", 32'(state), 32'd0);
    check("rst/trap", 32'(trap), 32'd0);
    check("rst/cause", 32'(trap_cause), 32'd0);
    check("rst/retired", 32'(retired), 32'd0);
    cyc();
    run = 1'b0;
    rst = 1'b0;
    #1;
    check("idle/ctl", 32'(ctl), 32'(C_NONE));
    cyc();
    check("idle/state", 32'(state), 32'd0);

    do_instr("op", OP_OP, 1'b0, 0, WB_ALU);
    check("op/retired", 32'(retired), 32'd1);
    check("op/back", 32'(state), 32'd0);
    do_instr("load", OP_LOAD, 1'b0, 3, WB_LD);
    check("load/retired", 32'(retired), 32'd2);
    funct3_store = 1'b1;
    do_instr("store", OP_STORE, 1'b0, 3, WB_NORF);
    funct3_store = 1'b0;
    check("store/retired", 32'(retired), 32'd3);
    do_instr("brt", OP_BRANCH, 1'b1, 0, WB_TAKEN);
    do_instr("brn", OP_BRANCH, 1'b0, 0, WB_NORF);
    do_instr("jal", OP_JAL, 1'b0, 0, WB_JMP);
    do_instr("jalr", OP_JALR, 1'b0, 0, WB_JMP);
    check("jmp/retired", 32'(retired), 32'd7);

    // Request held after run falls.
    opcode    = OP_OP;
    run       = 1'b1;
    mem_ready = 1'b0;
    expect_cyc("rd0", 3'd0, C_FREQ);
    run = 1'b0;
    expect_cyc("rd1", 3'd0, C_FREQ);
    mem_ready = 1'b1;
    expect_cyc("rd2", 3'd0, C_IFETCH);
    expect_cyc("rd/D", 3'd1, C_NONE);
    expect_cyc("rd/E", 3'd2, C_NONE);
    expect_cyc("rd/W", 3'd4, WB_ALU);
    check("rd/retired", 32'(retired), 32'd8);

    // Ready on the last permitted cycle wins over the timeout.
    run       = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) expect_cyc("resc/w", 3'd0, C_FREQ);
    mem_ready = 1'b1;
    expect_cyc("resc/hs", 3'd0, C_IFETCH);
    run = 1'b0;
    check("resc/state", 32'(state), 32'd1);
    check("resc/trap", 32'(trap), 32'd0);
    expect_cyc("resc/D", 3'd1, C_NONE);
    expect_cyc("resc/E", 3'd2, C_NONE);
    expect_cyc("resc/W", 3'd4, WB_ALU);
    check("resc/retired", 32'(retired), 32'd9);

    for (int k = 10; k <= 16; k++) begin
      do_instr("wrap", OP_OP, 1'b0, 0, WB_ALU);
      check("wrap/retired", 32'(retired), 32'(k % 16));
    end

    // Reset in the middle of a load data access.
    do_instr("pre", OP_OP, 1'b0, 0, WB_ALU);
    check("pre/retired", 32'(retired), 32'd1);
    opcode    = OP_LOAD;
    run       = 1'b1;
    mem_ready = 1'b1;
    expect_cyc("mr/F", 3'd0, C_IFETCH);
    run = 1'b0;
    expect_cyc("mr/D", 3'd1, C_NONE);
    expect_cyc("mr/E", 3'd2, C_NONE);
    mem_ready = 1'b0;
    expect_cyc("mr/M", 3'd3, C_LD);
    rst       = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("mr/state", 32'(state), 32'd0);
    check("mr/ctl", 32'(ctl), 32'(C_NONE));
    check("mr/retired", 32'(retired), 32'd0);
    cyc();
    rst = 1'b0;

    // Fetch timeout.
    opcode    = OP_OP;
    run       = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_cyc("to/w", 3'd0, C_FREQ);
    #1;
    check("to/state", 32'(state), 32'd5);
    check("to/trap", 32'(trap), 32'd1);
    check("to/cause", 32'(trap_cause), 32'd2);
    check("to/ctl", 32'(ctl), 32'(C_NONE));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("to/rst_trap", 32'(trap), 32'd0);

    // Illegal opcode trap is absorbing and freezes retired.
    do_instr("pre2", OP_OP, 1'b0, 0, WB_ALU);
    opcode    = OP_SYSTEM;
    run       = 1'b1;
    mem_ready = 1'b1;
    expect_cyc("ill/F", 3'd0, C_IFETCH);
    expect_cyc("ill/D", 3'd1, C_NONE);
    check("ill/cause", 32'(trap_cause), 32'd1);
    check("ill/trap", 32'(trap), 32'd1);
    bra_taken = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("ill/state", 32'(state), 32'd5);
      check("ill/ctl", 32'(ctl), 32'(C_NONE));
      check("ill/retired", 32'(retired), 32'd1);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
